adder_seq_nb: RTL and testbench



---
 rtl/adder_seq_nb.sv | 126 ++++++++++++
 tb/tb_adder_seq_nb.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/adder_seq_nb.sv
// Multi-cycle adder/subtractor that processes CHUNK bits per clock, LSB chunk first.
// The result and flags are published on sum/co/ovf only when the last chunk completes.
module adder_seq_nb #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             ready,
  output logic             busy,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             done
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] CHUNK_MASK = WIDTH'({CHUNK{1'b1}});

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] part_q, part_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [31:0]      shamt;
  logic [CHUNK-1:0] a_ch, b_ch;
  logic [CHUNK:0]   add_w;
  logic             msb_cin;

  // Current chunk slice and its CHUNK-bit add with the running carry.
  assign shamt = 32'(idx_q) * 32'(CHUNK);
  assign a_ch  = CHUNK'(a_q >> shamt);
  assign b_ch  = CHUNK'(b_q >> shamt);
  assign add_w = {1'b0, a_ch} + {1'b0, b_ch} + {{CHUNK{1'b0}}, carry_q};
  // Carry into the top bit recovered from its sum bit: s = a ^ b ^ cin.
  assign msb_cin = a_ch[CHUNK-1] ^ b_ch[CHUNK-1] ^ add_w[CHUNK-1];

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : ci;
          idx_d   = '0;
        end
      end
      RUN: begin
        part_d  = (part_q & ~(CHUNK_MASK << shamt))
                | (WIDTH'(add_w[CHUNK-1:0]) << shamt);
        carry_d = add_w[CHUNK];
        idx_d   = idx_q + IDX_W'(1);
        if (idx_q == LAST_IDX) begin
          state_d = DONE;
          idx_d   = '0;
          sum_d   = part_d;
          co_d    = add_w[CHUNK];
          ovf_d   = msb_cin ^ add_w[CHUNK];
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == IDLE);
  assign busy  = ~ready;
  assign sum   = sum_q;
  assign co    = co_q;
  assign ovf   = ovf_q;
  assign done  = done_q;

endmodule

// File: tb/tb_adder_seq_nb.sv
// Directed and random checks of adder_seq_nb at CHUNK=4 (main), CHUNK=1 and CHUNK=16.
module tb_adder_seq_nb;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] a, b;
  logic        sub, ci;
  logic [2:0]  st;
  logic [2:0]  rdy, bsy, co_w, ovf_w, dn;
  logic [15:0] sum_w [3];

  int n_chk  = 0;
  int n_pass = 0;
  int nch [3] = '{4, 16, 1};

  always #5 clk = ~clk;

  adder_seq_nb #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .start(st[0]), .sub(sub), .a(a), .b(b), .ci(ci),
    .ready(rdy[0]), .busy(bsy[0]), .sum(sum_w[0]), .co(co_w[0]), .ovf(ovf_w[0]), .done(dn[0]));

  adder_seq_nb #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(st[1]), .sub(sub), .a(a), .b(b), .ci(ci),
    .ready(rdy[1]), .busy(bsy[1]), .sum(sum_w[1]), .co(co_w[1]), .ovf(ovf_w[1]), .done(dn[1]));

  adder_seq_nb #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .start(st[2]), .sub(sub), .a(a), .b(b), .ci(ci),
    .ready(rdy[2]), .busy(bsy[2]), .sum(sum_w[2]), .co(co_w[2]), .ovf(ovf_w[2]), .done(dn[2]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: returns {ovf, co, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic s, input logic c);
    logic [16:0] r;
    logic        cf, ov;
    if (s) begin
      r  = {1'b0, x} - {1'b0, y};
      cf = ~r[16];
      ov = (x[15] != y[15]) && (r[15] != x[15]);
    end else begin
      r  = {1'b0, x} + {1'b0, y} + {16'd0, c};
      cf = r[16];
      ov = (x[15] == y[15]) && (r[15] != x[15]);
    end
    return {ov, cf, r[15:0]};
  endfunction

  task automatic do_op(input int k, input logic [15:0] xa, input logic [15:0] xb,
                       input logic xs, input logic xc, input logic [15:0] es,
                       input logic eco, input logic eov, input bit pester);
    int lat, bcnt;
    chk("ready_before", 32'(rdy[k]), 32'd1);
    a = xa; b = xb; sub = xs; ci = xc; st[k] = 1'b1;
    tick();
    // Scrambled inputs and (optionally) a held start must not disturb the running op.
    st[k] = pester; a = ~xa; b = xb ^ 16'h5a5a; sub = ~xs; ci = ~xc;
    lat  = 0;
    bcnt = bsy[k] ? 1 : 0;
    while (!dn[k] && lat < 64) begin
      tick();
      lat++;
      if (bsy[k]) bcnt++;
    end
    st[k] = 1'b0;
    chk("latency", 32'(lat), 32'(nch[k]));
    chk("sum", 32'(sum_w[k]), 32'(es));
    chk("co", 32'(co_w[k]), 32'(eco));
    chk("ovf", 32'(ovf_w[k]), 32'(eov));
    tick();
    chk("done_pulse", 32'(dn[k]), 32'd0);
    chk("idle_after", 32'(rdy[k]), 32'd1);
    chk("busy_cycles", 32'(bcnt), 32'(nch[k] + 1));
    chk("sum_hold", 32'(sum_w[k]), 32'(es));
  endtask

  initial begin
    int lat, seen;
    logic [17:0] m;
    logic [15:0] xa, xb;
    logic xs, xc;

    rst = 1'b1; st = '0; a = '0; b = '0; sub = 1'b0; ci = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("rst_ready", 32'(rdy[k]), 32'd1);
      chk("rst_busy", 32'(bsy[k]), 32'd0);
      chk("rst_sum", 32'(sum_w[k]), 32'd0);
      chk("rst_flags", {29'd0, co_w[k], ovf_w[k], dn[k]}, 32'd0);
    end

    do_op(0, 16'h0003, 16'h0001, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0);
    do_op(0, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    do_op(0, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op(0, 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    do_op(0, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);
    do_op(0, 16'h0003, 16'h0001, 1'b0, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b1);
    do_op(1, 16'h7FFF, 16'h0000, 1'b0, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    do_op(2, 16'h8000, 16'h0001, 1'b1, 1'b0, 16'h7FFF, 1'b1, 1'b1, 1'b0);

    // start held high across two operations
    a = 16'd1; b = 16'd2; sub = 1'b0; ci = 1'b0; st[0] = 1'b1;
    tick();
    a = 16'd10; b = 16'd20;
    lat = 0;
    while (!dn[0] && lat < 64) begin tick(); lat++; end
    chk("b2b_lat1", 32'(lat), 32'd4);
    chk("b2b_sum1", 32'(sum_w[0]), 32'd3);
    tick();
    chk("b2b_idle", 32'(rdy[0]), 32'd1);
    tick();
    chk("b2b_accept", 32'(bsy[0]), 32'd1);
    st[0] = 1'b0;
    lat = 0;
    while (!dn[0] && lat < 64) begin tick(); lat++; end
    chk("b2b_lat2", 32'(lat), 32'd4);
    chk("b2b_sum2", 32'(sum_w[0]), 32'd30);
    tick();

    // reset aborts an in-flight operation
    a = 16'h1111; b = 16'h2222; st[0] = 1'b1;
    tick();
    st[0] = 1'b0;
    tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort_ready", 32'(rdy[0]), 32'd1);
    chk("abort_sum", 32'(sum_w[0]), 32'd0);
    seen = 0;
    repeat (8) begin
      tick();
      if (dn[0]) seen = 1;
    end
    chk("abort_nodone", 32'(seen), 32'd0);
    chk("abort_sum_hold", 32'(sum_w[0]), 32'd0);
    do_op(0, 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);

    for (int k = 0; k < 3; k++) begin
      for (int n = 0; n < 100; n++) begin
        xa = 16'($urandom);
        xb = 16'($urandom);
        xs = 1'($urandom_range(0, 1));
        xc = 1'($urandom_range(0, 1));
        m  = model(xa, xb, xs, xc);
        do_op(k, xa, xb, xs, xc, m[15:0], m[16], m[17], bit'($urandom_range(0, 1)));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
